// File: rtl/rx_serial_7e1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rx_serial_7e1
//  Purpose  : 7E1 asynchronous serial receiver (1 start, 7 data LSB first,
//             even parity, 1 stop) with mid-bit sampling and a
//             hold-until-consumed data handshake.
//  Options  : RX_SERIAL_OVERRUN_EN adds the erro_overrun status output.
//  Revision : 1.0 - initial release
// ============================================================================
module rx_serial_7e1 #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dados_serial,
    input  logic       recebe_dado,
    output logic [6:0] dados_ascii,
    output logic       pronto,
    output logic       tem_dado,
    output logic       erro_paridade,
    output logic       erro_stop,
`ifdef RX_SERIAL_OVERRUN_EN
    output logic       erro_overrun,
`endif
    output logic [3:0] db_estado
);

    // Clocks per bit, half bit, and counter width
    localparam int c_clks_bit = CLK_FREQ / BAUD_RATE;
    localparam int c_clks_half = c_clks_bit / 2;
    localparam int c_cw = (c_clks_bit > 1) ? $clog2(c_clks_bit) : 1;
    localparam logic [c_cw-1:0] c_bit_last  = c_cw'(c_clks_bit - 1);
    localparam logic [c_cw-1:0] c_half_last = c_cw'(c_clks_half - 1);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        START    = 4'd1,
        DADOS    = 4'd2,
        PARIDADE = 4'd3,
        STOP     = 4'd4,
        FINAL    = 4'd5,
        ESPERA   = 4'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_sync1;
    logic            r_sync2;
    logic [c_cw-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic [6:0]      r_shift;
    logic            r_par;
    logic            w_line;
    logic            w_tick;
    logic            w_timed;
    logic            w_latch;

    assign w_line    = r_sync2;
    assign db_estado = r_state;

    // Two-flop synchronizer for the asynchronous serial pin (idles high)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= dados_serial;
            r_sync2 <= r_sync1;
        end
    end

    // Sample strobe: half a bit into the start bit, full bits afterwards
    always_comb begin
        w_tick  = 1'b0;
        w_timed = 1'b0;
        case (r_state)
            START: begin
                w_timed = 1'b1;
                w_tick  = (r_cnt == c_half_last);
            end
            DADOS, PARIDADE, STOP: begin
                w_timed = 1'b1;
                w_tick  = (r_cnt == c_bit_last);
            end
            default: ;
        endcase
    end

    assign w_latch = (r_state == STOP) && w_tick;

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= INICIAL;
        else        r_state <= w_next;
    end

    // Next-state logic and the one-cycle completion pulse
    always_comb begin
        w_next = r_state;
        pronto = 1'b0;
        case (r_state)
            INICIAL:  if (!w_line) w_next = START;
            START:    if (w_tick) w_next = w_line ? INICIAL : DADOS;
            DADOS:    if (w_tick && (r_idx == 3'd6)) w_next = PARIDADE;
            PARIDADE: if (w_tick) w_next = STOP;
            STOP:     if (w_tick) w_next = FINAL;
            FINAL: begin
                pronto = 1'b1;
                w_next = erro_stop ? ESPERA : INICIAL;
            end
            ESPERA:   if (w_line) w_next = INICIAL;
            default:  w_next = INICIAL;
        endcase
    end

    // Bit timing counter and data bit index; both restart outside their states
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else begin
            r_cnt <= (w_timed && !w_tick) ? r_cnt + 1'b1 : '0;
            if (r_state != DADOS) r_idx <= 3'd0;
            else if (w_tick)      r_idx <= r_idx + 3'd1;
        end
    end

    // Shift register and parity capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            if ((r_state == DADOS) && w_tick)    r_shift[r_idx] <= w_line;
            if ((r_state == PARIDADE) && w_tick) r_par <= w_line;
        end
    end

    // Output latch at the stop sample; a new frame wins over the acknowledge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dados_ascii   <= '0;
            erro_paridade <= 1'b0;
            erro_stop     <= 1'b0;
            tem_dado      <= 1'b0;
        end else if (w_latch) begin
            dados_ascii   <= r_shift;
            erro_paridade <= r_par ^ (^r_shift);
            erro_stop     <= ~w_line;
            tem_dado      <= 1'b1;
        end else if (recebe_dado) begin
            tem_dado      <= 1'b0;
        end
    end

`ifdef RX_SERIAL_OVERRUN_EN
    // Overrun: a frame landed on unread data that was not consumed this cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                   erro_overrun <= 1'b0;
        else if (w_latch && tem_dado && !recebe_dado) erro_overrun <= 1'b1;
        else if (recebe_dado)                         erro_overrun <= 1'b0;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rx_serial_7e1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rx_serial_7e1
//  Purpose  : Scoreboard bench for rx_serial_7e1 (M = 16, H = 8).
//             Build with RX_SERIAL_OVERRUN_EN to cover the overrun output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rx_serial_7e1;

    localparam int c_m = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       dados_serial = 1'b1;
    logic       recebe_dado = 1'b0;
    logic [6:0] dados_ascii;
    logic       pronto;
    logic       tem_dado;
    logic       erro_paridade;
    logic       erro_stop;
    logic [3:0] db_estado;
`ifdef RX_SERIAL_OVERRUN_EN
    logic       erro_overrun;
`endif

    typedef struct {
        logic [6:0] d;
        logic       pe;
        logic       se;
        logic       ov;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic r_prev_pronto = 1'b0;

    rx_serial_7e1 #(.CLK_FREQ(1600), .BAUD_RATE(100)) dut (
        .clock         (clock),
        .reset         (reset),
        .dados_serial  (dados_serial),
        .recebe_dado   (recebe_dado),
        .dados_ascii   (dados_ascii),
        .pronto        (pronto),
        .tem_dado      (tem_dado),
        .erro_paridade (erro_paridade),
        .erro_stop     (erro_stop),
`ifdef RX_SERIAL_OVERRUN_EN
        .erro_overrun  (erro_overrun),
`endif
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Drives one frame; the line is left at the stop bit value
    task automatic send_bits(input logic [6:0] d, input logic p, input logic s);
        dados_serial = 1'b0;
        tick(c_m);
        for (int i = 0; i < 7; i++) begin
            dados_serial = d[i];
            tick(c_m);
        end
        dados_serial = p;
        tick(c_m);
        dados_serial = s;
        tick(c_m);
    endtask

    task automatic frame(input logic [6:0] d, input logic p, input logic s,
                         input logic pe, input logic se, input logic ov);
        exp_t e;
        e.d = d; e.pe = pe; e.se = se; e.ov = ov;
        q.push_back(e);
        send_bits(d, p, s);
    endtask

    task automatic ack();
        recebe_dado = 1'b1;
        tick(1);
        recebe_dado = 1'b0;
        chk("ack_tem_dado", {31'd0, tem_dado}, 32'd0);
    endtask

    // Monitor: every completion pulse is checked against the scoreboard
    always @(negedge clock) begin
        if (reset && pronto) begin
            chk("pronto_width", {31'd0, r_prev_pronto}, 32'd0);
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pronto: got data %0h expected no frame", dados_ascii);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data", {25'd0, dados_ascii}, {25'd0, e.d});
                chk("erro_paridade", {31'd0, erro_paridade}, {31'd0, e.pe});
                chk("erro_stop", {31'd0, erro_stop}, {31'd0, e.se});
                chk("tem_dado_at_pronto", {31'd0, tem_dado}, 32'd1);
`ifdef RX_SERIAL_OVERRUN_EN
                chk("erro_overrun", {31'd0, erro_overrun}, {31'd0, e.ov});
`endif
            end
        end
        r_prev_pronto = pronto;
    end

    initial begin
        // Reset state
        tick(3);
        chk("rst_estado", {28'd0, db_estado}, 32'd0);
        chk("rst_data", {25'd0, dados_ascii}, 32'd0);
        chk("rst_flags", {28'd0, pronto, tem_dado, erro_paridade, erro_stop}, 32'd0);
        reset = 1'b1;
        tick(5);

        // 1: 'A' 0x41, two ones -> parity 0
        frame(7'h41, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4);
        chk("A_estado_idle", {28'd0, db_estado}, 32'd0);
        chk("A_tem_dado", {31'd0, tem_dado}, 32'd1);
        ack();

        // 2: 'C' 0x43 has three ones, parity bit 0 is wrong; '0' 0x30 parity 0
        frame(7'h43, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(4);
        ack();
        frame(7'h30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4);
        ack();

        // 3: glitch of H/2 cycles -> false start
        dados_serial = 1'b0;
        tick(4);
        chk("glitch_in_start", {28'd0, db_estado}, 32'd1);
        dados_serial = 1'b1;
        tick(20);
        chk("glitch_estado", {28'd0, db_estado}, 32'd0);
        chk("glitch_data", {25'd0, dados_ascii}, 32'h30);
        chk("glitch_tem_dado", {31'd0, tem_dado}, 32'd0);

        // 4: 0x55 (four ones, parity 0) with stop 0 and a held break
        frame(7'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(c_m);
        chk("break_espera", {28'd0, db_estado}, 32'd6);
        tick(2 * c_m);
        chk("break_espera_late", {28'd0, db_estado}, 32'd6);
        dados_serial = 1'b1;
        tick(4);
        chk("break_release", {28'd0, db_estado}, 32'd0);
        chk("break_erro_stop_held", {31'd0, erro_stop}, 32'd1);
        ack();
        frame(7'h31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4);
        ack();

        // 5: back-to-back 0x31, 0x32 (three ones each -> parity 1), no ack between
        frame(7'h31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(7'h32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(4);
        chk("b2b_data", {25'd0, dados_ascii}, 32'h32);
        chk("b2b_tem_dado", {31'd0, tem_dado}, 32'd1);
`ifdef RX_SERIAL_OVERRUN_EN
        chk("b2b_overrun_set", {31'd0, erro_overrun}, 32'd1);
`endif
        ack();
`ifdef RX_SERIAL_OVERRUN_EN
        chk("b2b_overrun_clr", {31'd0, erro_overrun}, 32'd0);
`endif

        // 6: reset in the middle of 0x7F, then 0x2D (four ones -> parity 0)
        dados_serial = 1'b0;
        tick(c_m);
        for (int i = 0; i < 3; i++) begin
            dados_serial = 1'b1;
            tick(c_m);
        end
        reset = 1'b0;
        #1;
        chk("midrst_estado", {28'd0, db_estado}, 32'd0);
        chk("midrst_data", {25'd0, dados_ascii}, 32'd0);
        chk("midrst_flags", {28'd0, pronto, tem_dado, erro_paridade, erro_stop}, 32'd0);
        dados_serial = 1'b1;
        tick(5);
        reset = 1'b1;
        tick(5);
        frame(7'h2D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4);
        chk("final_data", {25'd0, dados_ascii}, 32'h2D);
        chk("frames_outstanding", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
